// File: rtl/ps2_movement_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ps2_movement_decoder                                              |
// | Desc   : PS/2 keyboard receiver that tracks make/break codes of the arrow  |
// |          keys and holds four movement flags for player_updater. Also      |
// |          exposes the last good byte and a frame-error strobe for debug.   |
// |          Optional macro PS2_WASD_EN adds W/A/S/D as aliases of the arrows.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ps2_movement_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       turn_right,
  output logic       turn_left,
  output logic       move_forward,
  output logic       move_backward,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       frame_error
);

  localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // Held-bit / movement vector layout
  localparam int B_RIGHT = 0;
  localparam int B_LEFT  = 1;
  localparam int B_FWD   = 2;
  localparam int B_BACK  = 3;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_dat_sync;
  logic          r_clk_last;
  logic          w_edge;
  logic          w_bit;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic [7:0]    r_shift;
  logic [2:0]    r_bitcnt;
  logic          r_parity;
  logic [CW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_frame_ok;
  logic          w_frame_bad;

  logic [7:0]    r_scan_code;
  logic          r_scan_valid;
  logic          r_frame_error;

  logic          r_ext;
  logic          r_brk;
  logic          w_ext_next;
  logic          w_brk_next;
  logic [3:0]    r_held_arrow;
  logic [3:0]    w_arrow_next;
`ifdef PS2_WASD_EN
  logic [3:0]    r_held_letter;
  logic [3:0]    w_letter_next;
`endif
  logic [3:0]    w_moves_next;
  logic [3:0]    r_moves;

  // Two-flop synchronisers; idle level of the PS/2 lines is high, so reset to 1
  // to avoid a phantom falling edge after reset release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_last <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
      r_clk_last <= r_clk_sync[1];
    end
  end

  assign w_edge = r_clk_last & ~r_clk_sync[1];
  assign w_bit  = r_dat_sync[1];

  // A PS/2 edge in the same cycle as the timeout keeps the frame alive.
  assign w_timeout = (r_state != S_IDLE) && !w_edge && (r_to_cnt == TO_LAST);

  // FSM state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic: one step per PS/2 falling edge
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = S_IDLE;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE:   if (!w_bit) w_state_next = S_DATA;
        S_DATA:   if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
        S_PARITY: w_state_next = S_STOP;
        S_STOP:   w_state_next = S_IDLE;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // FSM outputs: frame verdict at the stop bit (odd parity over data+parity, stop=1)
  always_comb begin
    w_frame_ok  = 1'b0;
    w_frame_bad = w_timeout;
    if (w_edge && (r_state == S_STOP)) begin
      if ((^{r_shift, r_parity}) && w_bit) begin
        w_frame_ok = 1'b1;
      end else begin
        w_frame_bad = 1'b1;
      end
    end
  end

  // Frame datapath: LSB-first shift register, bit counter and parity capture
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 3'd0;
      r_parity <= 1'b0;
    end else if (w_edge) begin
      case (r_state)
        S_IDLE: r_bitcnt <= 3'd0;
        S_DATA: begin
          r_shift  <= {w_bit, r_shift[7:1]};
          r_bitcnt <= r_bitcnt + 3'd1;
        end
        S_PARITY: r_parity <= w_bit;
        default: ;
      endcase
    end
  end

  // Inactivity counter: cleared on every edge and while idle, saturates at the limit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_to_cnt <= '0;
    end else if ((r_state == S_IDLE) || w_edge) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt != TO_LAST) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Registered byte output and one-cycle strobes
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_scan_code   <= 8'h00;
      r_scan_valid  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_scan_valid  <= w_frame_ok;
      r_frame_error <= w_frame_bad;
      if (w_frame_ok) begin
        r_scan_code <= r_shift;
      end
    end
  end

  // Make/break decoder, evaluated in the cycle scan_valid is high
  always_comb begin
    w_ext_next   = r_ext;
    w_brk_next   = r_brk;
    w_arrow_next = r_held_arrow;
`ifdef PS2_WASD_EN
    w_letter_next = r_held_letter;
`endif
    if (r_frame_error) begin
      w_ext_next = 1'b0;
      w_brk_next = 1'b0;
    end else if (r_scan_valid) begin
      case (r_scan_code)
        8'hE0: w_ext_next = 1'b1;
        8'hF0: w_brk_next = 1'b1;
        default: begin
          if (r_ext) begin
            case (r_scan_code)
              8'h74:   w_arrow_next[B_RIGHT] = ~r_brk;
              8'h6B:   w_arrow_next[B_LEFT]  = ~r_brk;
              8'h75:   w_arrow_next[B_FWD]   = ~r_brk;
              8'h72:   w_arrow_next[B_BACK]  = ~r_brk;
              default: ;
            endcase
          end
`ifdef PS2_WASD_EN
          else begin
            case (r_scan_code)
              8'h23:   w_letter_next[B_RIGHT] = ~r_brk;
              8'h1C:   w_letter_next[B_LEFT]  = ~r_brk;
              8'h1D:   w_letter_next[B_FWD]   = ~r_brk;
              8'h1B:   w_letter_next[B_BACK]  = ~r_brk;
              default: ;
            endcase
          end
`endif
          w_ext_next = 1'b0;
          w_brk_next = 1'b0;
        end
      endcase
    end
`ifdef PS2_WASD_EN
    w_moves_next = w_arrow_next | w_letter_next;
`else
    w_moves_next = w_arrow_next;
`endif
  end

  // Prefix flags, held bits and registered movement outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_ext         <= 1'b0;
      r_brk         <= 1'b0;
      r_held_arrow  <= 4'h0;
`ifdef PS2_WASD_EN
      r_held_letter <= 4'h0;
`endif
      r_moves       <= 4'h0;
    end else begin
      r_ext         <= w_ext_next;
      r_brk         <= w_brk_next;
      r_held_arrow  <= w_arrow_next;
`ifdef PS2_WASD_EN
      r_held_letter <= w_letter_next;
`endif
      r_moves       <= w_moves_next;
    end
  end

  assign turn_right    = r_moves[B_RIGHT];
  assign turn_left     = r_moves[B_LEFT];
  assign move_forward  = r_moves[B_FWD];
  assign move_backward = r_moves[B_BACK];
  assign scan_code     = r_scan_code;
  assign scan_valid    = r_scan_valid;
  assign frame_error   = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_movement_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ps2_movement_decoder                                           |
// | Desc   : Directed bench for ps2_movement_decoder; good frames push their  |
// |          byte to a scoreboard that is popped on every scan_valid pulse.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_ps2_movement_decoder;

  localparam int TO   = 200;
  localparam int HALF = 10;

  logic       clock   = 1'b0;
  logic       resetn  = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       turn_right, turn_left, move_forward, move_backward;
  logic [7:0] scan_code;
  logic       scan_valid, frame_error;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fe_count = 0;
  int fe_base = 0;
  int last_sv_cyc = -1;
  int mf_rise_cyc = -1;
  logic mf_prev = 1'b0;
  logic [7:0] exp_q[$];

  ps2_movement_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .turn_right(turn_right), .turn_left(turn_left),
    .move_forward(move_forward), .move_backward(move_backward),
    .scan_code(scan_code), .scan_valid(scan_valid), .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {back, fwd, left, right}
  function automatic logic [3:0] moves();
    return {move_backward, move_forward, turn_left, turn_right};
  endfunction

  // Scoreboard / event monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (frame_error) fe_count++;
    if (move_forward && !mf_prev) mf_rise_cyc = cyc;
    mf_prev = move_forward;
    if (scan_valid) begin
      last_sv_cyc = cyc;
      if (exp_q.size() == 0) check("sv_unexpected", {31'd0, scan_valid}, 32'd0);
      else check("scan_code_sb", {24'd0, scan_code}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clock); ps2_dat = b;
    repeat (HALF) @(negedge clock); ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock); ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit good = 1'b1);
    if (good) exp_q.push_back(b);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(good ? ~^b : ^b);
    ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (2 * HALF) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    #2 resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", {18'd0, moves(), scan_code, scan_valid, frame_error}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clock);

    // 1: Up make
    send(8'hE0); send(8'h75);
    check("t1_moves", {28'd0, moves()}, 32'h4);
    check("t1_mf_latency", mf_rise_cyc, last_sv_cyc + 1);

    // 2: Up break
    fe_base = fe_count;
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_moves", {28'd0, moves()}, 32'h0);
    check("t2_scan_code", {24'd0, scan_code}, 32'h75);
    check("t2_no_fe", fe_count, fe_base);

    // 3: bad parity on 72 drops ext
    fe_base = fe_count;
    send(8'hE0); send(8'h72, 1'b0);
    check("t3_fe", fe_count, fe_base + 1);
    check("t3_scan_code", {24'd0, scan_code}, 32'hE0);
    check("t3_moves", {28'd0, moves()}, 32'h0);
    send(8'h72);
    check("t3_moves_after", {28'd0, moves()}, 32'h0);

    // 4: partial frame then timeout
    fe_base = fe_count;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    repeat (TO + 20) @(negedge clock);
    check("t4_timeout_fe", fe_count, fe_base + 1);
    send(8'hE0); send(8'h74);
    check("t4_moves", {28'd0, moves()}, 32'h1);
    check("t4_fe_total", fe_count, fe_base + 1);

    // 5: Left held, reset mid-frame
    send(8'hE0); send(8'h6B);
    check("t5_moves_held", {28'd0, moves()}, 32'h3);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clock); #2 resetn = 1'b0;
    #1 check("t5_reset_outputs", {18'd0, moves(), scan_code, scan_valid, frame_error}, 32'd0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (5) @(negedge clock);
    fe_base = fe_count;
    send(8'hE0); send(8'h74);
    check("t5_moves_after", {28'd0, moves()}, 32'h1);
    check("t5_no_fe", fe_count, fe_base);

    // 6: letter aliases
    send(8'hE0); send(8'hF0); send(8'h74);
    check("t6_release_right", {28'd0, moves()}, 32'h0);
`ifdef PS2_WASD_EN
    send(8'h1D);
    check("t6_w_make", {28'd0, moves()}, 32'h4);
    send(8'hE0); send(8'h75);
    check("t6_up_make", {28'd0, moves()}, 32'h4);
    send(8'hF0); send(8'h1D);
    check("t6_w_break", {28'd0, moves()}, 32'h4);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t6_up_break", {28'd0, moves()}, 32'h0);
`else
    send(8'h1D);
    check("t6_w_unmapped", {28'd0, moves()}, 32'h0);
    check("t6_scan_code", {24'd0, scan_code}, 32'h1D);
`endif

    repeat (10) @(negedge clock);
    check("sb_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
